mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles to wait for ext_ack before aborting; legal range 1..255.
REQ-002 Parameter ERRDATA, default 32'hDEADBEEF: readdata value returned on any aborted read.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 memreq  input  1  core access request; held until memready.
REQ-006 memwrite  input  1  1 = write, 0 = read; valid with memreq.
REQ-007 adr  input  32  core byte address; valid with memreq.
REQ-008 writedata  input  32  store data; valid with memreq & memwrite.
REQ-009 readdata  output  32  load data; valid in the memready cycle and held until the next completion.
REQ-010 memready  output  1  one-cycle completion pulse to the core stall logic.
REQ-011 memerr  output  1  one-cycle pulse coincident with memready when the access aborted.
REQ-012 ext_req, ext_we  output  1 each  external bus request and write strobe.
REQ-013 ext_adr  output  30  word address, equal to adr[31:2].
REQ-014 ext_wdata  output  32  external write data.
REQ-015 ext_rdata  input  32  external read data, valid with ext_ack.
REQ-016 ext_ack  input  1  external completion; ignored unless ext_req is high.

Function
REQ-017 FSM states: IDLE, BUS, RESP, ERR; encodings are defined in the package.
REQ-018 IDLE: memreq=1 with adr[1:0]==0 -> BUS; memreq=1 with adr[1:0]!=0 -> ERR, with no external access; otherwise stay in IDLE.
REQ-019 On leaving IDLE, adr, writedata and memwrite are latched; ext_* outputs are driven only from the latched copies.
REQ-020 BUS: ext_req=1, ext_we=latched memwrite; ext_ack=1 -> RESP, capturing ext_rdata on reads.
REQ-021 Minimum read latency: memreq sampled at edge N, ext_req high after N, ack sampled at edge N+1, memready high after N+1 (2 cycles).
REQ-022 BUS counter: resets to 0 on entry and increments each cycle without ack; ack absent at count TIMEOUT -> ERR, and ext_req drops.
REQ-023 RESP: memready=1, memerr=0, then -> IDLE.
REQ-024 ERR: memready=1, memerr=1, readdata=ERRDATA (reads only; writes leave readdata unchanged), then -> IDLE.
REQ-025 Write completion leaves readdata unchanged.
REQ-026 ext_ack in the same cycle as a timeout: the ack wins, giving RESP.
REQ-027 memreq dropped mid-access is ignored; the access completes and memready still pulses.
REQ-028 memreq high in the RESP or ERR cycle is not sampled; it is accepted in the following IDLE cycle.

Reset
REQ-029 reset low forces the following: state=IDLE, counter=0, readdata=0, memready=0, memerr=0, ext_req=0, ext_we=0, ext_adr=0, ext_wdata=0.
REQ-030 An asserted reset aborts an in-flight access immediately with no memready, and ext_req falls asynchronously.

Configuration
REQ-031 Macro MEM_CTRL_WBUF_EN enables a one-entry posted write buffer.
REQ-032 When defined, an aligned write with an empty buffer loads the buffer in IDLE and pulses memready on the next cycle; the buffer drains via BUS, and a drain timeout sets a sticky flag that pulses memerr on the next completion.
REQ-033 When defined, any request made while the buffer is full waits in IDLE until the drain completes, which preserves read-after-write ordering.
REQ-034 When undefined, writes follow REQ-018..024 with no buffering.

Structure
REQ-035 Package mem_ctrl_pkg holds the state typedef, the ERRDATA default and the word-address width constant (30).
REQ-036 Sub-module mem_timeout holds the BUS counter: inputs clear and enable, output expired.

Verification
REQ-037 Read adr=0x100, ack 1 cycle after ext_req with ext_rdata=0x12345678 -> ext_adr=0x40, memready pulse 2 cycles after memreq, readdata=0x12345678, memerr=0.
REQ-038 Read with ack never asserted, TIMEOUT=15 -> ext_req high for 16 cycles, then memready=1, memerr=1, readdata=0xDEADBEEF.
REQ-039 Write adr=0x202 -> no ext_req, memready=memerr=1 on the next cycle, readdata unchanged.
REQ-040 Write 0xCAFEF00D to 0x80, then a read of 0x80 -> ext_we=1 with ext_wdata=0xCAFEF00D, then the read returns ext_rdata; with the macro defined, the write memready comes 1 cycle after memreq and the read's ext_req starts only after the write ack.
REQ-041 reset pulsed low while in BUS -> ext_req=0 immediately, no memready, next request handled normally.
REQ-042 ext_ack arriving in the same cycle the count reaches TIMEOUT -> memready with memerr=0 and the ack data returned.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the memory controller slice.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [31:0] ERRDATA_DEFAULT = 32'hDEADBEEF;
  localparam int unsigned WADR_W         = 30;
  localparam int unsigned TMO_CNT_W      = 8;

endpackage

// File: rtl/mem_timeout.sv
// mem_timeout: bus-wait counter; expired is high once the count reaches TIMEOUT.
module mem_timeout
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_CNT_W-1:0] LIMIT = TMO_CNT_W'(TIMEOUT);

  logic [TMO_CNT_W-1:0] cnt;

  // count cycles spent waiting; clear has priority over enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + TMO_CNT_W'(1);
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: core-to-external-bus memory controller with timeout abort.
// Optional macro MEM_CTRL_WBUF_EN adds a one-entry posted write buffer.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [31:0] ERRDATA = ERRDATA_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memreq,
  input  logic              memwrite,
  input  logic [31:0]       adr,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              memready,
  output logic              memerr,
  output logic              ext_req,
  output logic              ext_we,
  output logic [WADR_W-1:0] ext_adr,
  output logic [31:0]       ext_wdata,
  input  logic [31:0]       ext_rdata,
  input  logic              ext_ack
);

  state_t            state, state_nxt;
  logic [WADR_W-1:0] adr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              aligned;
  logic              accept;
  logic              err_we;
  logic              tmo_clear, tmo_en, expired;

  assign aligned = (adr[1:0] == 2'b00);

`ifdef MEM_CTRL_WBUF_EN
  logic wbuf_full;
  logic drain_err;

  assign accept = (state == IDLE) && !wbuf_full && memreq;
`else
  assign accept = (state == IDLE) && memreq;
`endif

  mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (expired)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state and timeout counter control
  always_comb begin
    state_nxt = state;
    tmo_clear = 1'b0;
    tmo_en    = 1'b0;
    unique case (state)
      IDLE: begin
        tmo_clear = 1'b1;
`ifdef MEM_CTRL_WBUF_EN
        // a full buffer drains before any new request is looked at
        if (wbuf_full)        state_nxt = BUS;
        else if (memreq) begin
          if (!aligned)       state_nxt = ERR;
          else if (memwrite)  state_nxt = RESP;
          else                state_nxt = BUS;
        end
`else
        if (memreq)           state_nxt = aligned ? BUS : ERR;
`endif
      end
      BUS: begin
`ifdef MEM_CTRL_WBUF_EN
        // a drain was already acknowledged to the core, so it ends silently
        if (wbuf_full) begin
          if (ext_ack || expired) state_nxt = IDLE;
          else                    tmo_en    = 1'b1;
        end else
`endif
        if (ext_ack)      state_nxt = RESP;
        else if (expired) state_nxt = ERR;
        else              tmo_en    = 1'b1;
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // latch the access when it is accepted out of IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adr_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      adr_q   <= adr[31:2];
      wdata_q <= writedata;
      we_q    <= memwrite;
    end
  end

  // an abort straight out of IDLE has not latched memwrite yet
  assign err_we = (state == IDLE) ? memwrite : we_q;

  // read data: bus data on read ack, ERRDATA on an aborted read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      readdata <= '0;
    else if (state == BUS && ext_ack && !we_q)
      readdata <= ext_rdata;
    else if (state_nxt == ERR && !err_we)
      readdata <= ERRDATA;
  end

`ifdef MEM_CTRL_WBUF_EN
  // posted-write occupancy and sticky drain-timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbuf_full <= 1'b0;
      drain_err <= 1'b0;
    end else begin
      if (accept && aligned && memwrite)
        wbuf_full <= 1'b1;
      else if (state == BUS && wbuf_full && (ext_ack || expired))
        wbuf_full <= 1'b0;
      if (memready)
        drain_err <= 1'b0;
      else if (state == BUS && wbuf_full && !ext_ack && expired)
        drain_err <= 1'b1;
    end
  end

  assign memerr = (state == ERR) || (state == RESP && drain_err);
`else
  assign memerr = (state == ERR);
`endif

  assign memready  = (state == RESP) || (state == ERR);
  assign ext_req   = (state == BUS);
  assign ext_we    = (state == BUS) && we_q;
  assign ext_adr   = adr_q;
  assign ext_wdata = wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl (default build).
module tb_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        memreq;
  logic        memwrite;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        memready;
  logic        memerr;
  logic        ext_req;
  logic        ext_we;
  logic [29:0] ext_adr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_ack;

  int unsigned nchecks = 0;
  int unsigned nerrors = 0;

  mem_ctrl #(.TIMEOUT(15), .ERRDATA(32'hDEADBEEF)) dut (
    .clk       (clk),
    .reset     (reset),
    .memreq    (memreq),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .readdata  (readdata),
    .memready  (memready),
    .memerr    (memerr),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_adr   (ext_adr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned req_cycles;
    bit          done;

    reset     = 1'b0;
    memreq    = 1'b0;
    memwrite  = 1'b0;
    adr       = '0;
    writedata = '0;
    ext_rdata = '0;
    ext_ack   = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_memready", memready, 0);
    chk("rst_memerr", memerr, 0);
    chk("rst_ext_req", ext_req, 0);
    chk("rst_ext_we", ext_we, 0);
    chk("rst_ext_adr", ext_adr, 0);
    chk("rst_ext_wdata", ext_wdata, 0);
    chk("rst_readdata", readdata, 0);
    reset = 1'b1;
    tick();

    // basic read, ack one cycle after ext_req
    memreq = 1'b1; memwrite = 1'b0; adr = 32'h100;
    tick();
    chk("rd_ext_req", ext_req, 1);
    chk("rd_ext_adr", ext_adr, 32'h40);
    chk("rd_ext_we", ext_we, 0);
    chk("rd_no_ready", memready, 0);
    ext_ack = 1'b1; ext_rdata = 32'h12345678;
    tick();
    chk("rd_ready", memready, 1);
    chk("rd_err", memerr, 0);
    chk("rd_data", readdata, 32'h12345678);
    chk("rd_req_drop", ext_req, 0);
    memreq = 1'b0; ext_ack = 1'b0; ext_rdata = 32'hFFFF0000;
    tick();
    chk("rd_pulse_end", memready, 0);
    chk("rd_data_hold", readdata, 32'h12345678);

    // misaligned write aborts without touching the bus
    memreq = 1'b1; memwrite = 1'b1; adr = 32'h202; writedata = 32'h11111111;
    tick();
    chk("mis_wr_req", ext_req, 0);
    chk("mis_wr_ready", memready, 1);
    chk("mis_wr_err", memerr, 1);
    chk("mis_wr_data", readdata, 32'h12345678);
    memreq = 1'b0; memwrite = 1'b0;
    tick();
    chk("mis_wr_idle", memready, 0);

    // memreq held through RESP is only taken in the following IDLE cycle
    memreq = 1'b1; memwrite = 1'b0; adr = 32'h108;
    tick();
    ext_ack = 1'b1; ext_rdata = 32'hA5A5A5A5;
    tick();
    chk("hold_ready", memready, 1);
    chk("hold_data", readdata, 32'hA5A5A5A5);
    ext_ack = 1'b0;
    tick();
    chk("hold_idle_req", ext_req, 0);
    chk("hold_idle_ready", memready, 0);
    tick();
    chk("hold_reaccept", ext_req, 1);
    chk("hold_adr", ext_adr, 32'h42);
    ext_ack = 1'b1; ext_rdata = 32'h0000BEEF;
    tick();
    chk("hold2_data", readdata, 32'h0000BEEF);
    memreq = 1'b0; ext_ack = 1'b0;
    tick();

    // read timeout, memreq dropped after acceptance
    memreq = 1'b1; memwrite = 1'b0; adr = 32'h104;
    req_cycles = 0; done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      memreq = 1'b0;
      if (ext_req) req_cycles++;
      if (memready) begin
        done = 1'b1;
        break;
      end
    end
    chk("tmo_done", done, 1);
    chk("tmo_req_cycles", req_cycles, 16);
    chk("tmo_err", memerr, 1);
    chk("tmo_data", readdata, 32'hDEADBEEF);
    chk("tmo_req_low", ext_req, 0);
    tick();

    // aligned write then read of the same word
    memreq = 1'b1; memwrite = 1'b1; adr = 32'h80; writedata = 32'hCAFEF00D;
    tick();
    chk("wr_req", ext_req, 1);
    chk("wr_we", ext_we, 1);
    chk("wr_wdata", ext_wdata, 32'hCAFEF00D);
    chk("wr_adr", ext_adr, 32'h20);
    ext_ack = 1'b1; ext_rdata = 32'h99999999;
    tick();
    chk("wr_ready", memready, 1);
    chk("wr_err", memerr, 0);
    chk("wr_data_keep", readdata, 32'hDEADBEEF);
    memreq = 1'b0; ext_ack = 1'b0;
    tick();
    memreq = 1'b1; memwrite = 1'b0; adr = 32'h80;
    tick();
    chk("raw_req", ext_req, 1);
    chk("raw_we", ext_we, 0);
    chk("raw_adr", ext_adr, 32'h20);
    ext_ack = 1'b1; ext_rdata = 32'hCAFEF00D;
    tick();
    chk("raw_ready", memready, 1);
    chk("raw_data", readdata, 32'hCAFEF00D);
    memreq = 1'b0; ext_ack = 1'b0;
    tick();

    // ack in the same cycle the count reaches TIMEOUT wins
    memreq = 1'b1; memwrite = 1'b0; adr = 32'h200;
    tick();
    chk("race_req", ext_req, 1);
    memreq = 1'b0;
    repeat (15) tick();
    chk("race_req_still", ext_req, 1);
    ext_ack = 1'b1; ext_rdata = 32'h5A5A0001;
    tick();
    chk("race_ready", memready, 1);
    chk("race_err", memerr, 0);
    chk("race_data", readdata, 32'h5A5A0001);
    ext_ack = 1'b0;
    tick();

    // reset mid-access
    memreq = 1'b1; memwrite = 1'b0; adr = 32'h300;
    tick();
    chk("rst_bus_req", ext_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_req", ext_req, 0);
    chk("rst_async_ready", memready, 0);
    chk("rst_async_data", readdata, 0);
    memreq = 1'b0;
    tick(); tick();
    chk("rst_hold_ready", memready, 0);
    reset = 1'b1;
    tick();
    chk("rst_after_ready", memready, 0);
    memreq = 1'b1; memwrite = 1'b0; adr = 32'h104;
    tick();
    chk("post_rst_req", ext_req, 1);
    chk("post_rst_adr", ext_adr, 32'h41);
    ext_ack = 1'b1; ext_rdata = 32'h77778888;
    tick();
    chk("post_rst_ready", memready, 1);
    chk("post_rst_data", readdata, 32'h77778888);
    memreq = 1'b0; ext_ack = 1'b0;
    tick();

    // misaligned read returns ERRDATA
    memreq = 1'b1; memwrite = 1'b0; adr = 32'h101;
    tick();
    chk("mis_rd_req", ext_req, 0);
    chk("mis_rd_ready", memready, 1);
    chk("mis_rd_err", memerr, 1);
    chk("mis_rd_data", readdata, 32'hDEADBEEF);
    memreq = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
